// File: rtl/io_walk_pattern.sv
// io_walk_pattern: firmware-controlled GPIO bring-up pattern generator.
// Walks a one across mprj_io[PAT_LSB+3:PAT_LSB], then drives all ones,
// optionally looping; pads outside the field are never driven.
module io_walk_pattern #(
    parameter int unsigned IO_WIDTH       = 38,
    parameter int unsigned PAT_LSB        = 8,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned DEFAULT_PERIOD = 1000
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic                start,
    input  logic                reg_we,
    input  logic [1:0]          reg_addr,
    input  logic [31:0]         reg_wdata,
    output logic [31:0]         reg_rdata,
    output logic [IO_WIDTH-1:0] io_out,
    output logic [IO_WIDTH-1:0] io_oeb,
    output logic [3:0]          pattern,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP0 = 3'd1,
        STEP1 = 3'd2,
        STEP2 = 3'd3,
        STEP3 = 3'd4,
        ALL   = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic             oe_en;
    logic             loop_en;

    logic             go;
    logic             ctrl_wr;
    logic             period_wr;
    logic [CNT_W-1:0] period_eff;
    logic             step_end;
    logic             unused_wdata;

    // Decode register strobes, the go condition and the step boundary
    always_comb begin
        ctrl_wr      = reg_we && (reg_addr == 2'd0);
        period_wr    = reg_we && (reg_addr == 2'd1);
        go           = start || (ctrl_wr && reg_wdata[1]);
        period_eff   = (period == '0) ? CNT_W'(1) : period;
        step_end     = (cnt >= (period_eff - CNT_W'(1)));
        unused_wdata = ^reg_wdata[31:CNT_W];
    end

    // Control and period registers; the start bit is a strobe and is not stored
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            oe_en   <= 1'b0;
            loop_en <= 1'b0;
            period  <= RST_PERIOD;
        end else begin
            if (ctrl_wr) begin
                oe_en   <= reg_wdata[0];
                loop_en <= reg_wdata[2];
            end
            if (period_wr) begin
                period <= reg_wdata[CNT_W-1:0];
            end
        end
    end

    // Sequencer: state, step counter and registered pattern/busy/done
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state   <= IDLE;
            cnt     <= '0;
            pattern <= 4'b0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state   <= STEP0;
                        cnt     <= '0;
                        pattern <= 4'b0001;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                STEP0, STEP1, STEP2, STEP3, ALL: begin
                    if (!step_end) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        case (state)
                            STEP0: begin
                                state   <= STEP1;
                                pattern <= 4'b0010;
                            end
                            STEP1: begin
                                state   <= STEP2;
                                pattern <= 4'b0100;
                            end
                            STEP2: begin
                                state   <= STEP3;
                                pattern <= 4'b1000;
                            end
                            STEP3: begin
                                state   <= ALL;
                                pattern <= 4'b1111;
                            end
                            default: begin
                                if (loop_en) begin
                                    state   <= STEP0;
                                    pattern <= 4'b0001;
                                end else begin
                                    state   <= DONE;
                                    pattern <= 4'b1111;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    pattern <= 4'b0000;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Combinational register read-back
    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            2'd0:    reg_rdata = {29'd0, loop_en, 1'b0, oe_en};
            2'd1:    reg_rdata = 32'(period);
            2'd2:    reg_rdata = {26'd0, done, busy, 1'b0, state};
            default: reg_rdata = {28'd0, pattern};
        endcase
    end

    // Pad mapping: only the pattern field can ever be enabled
    always_comb begin
        io_out                = '0;
        io_out[PAT_LSB +: 4]  = pattern;
        io_oeb                = '1;
        io_oeb[PAT_LSB +: 4]  = {4{~oe_en}};
    end

endmodule

// File: tb/tb_io_walk_pattern.sv
// Scoreboard bench for io_walk_pattern: a phase-level reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_io_walk_pattern;

    logic        clock = 1'b0;
    logic        resetb;
    logic        start;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic [3:0]  pattern;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    io_walk_pattern dut (
        .clock     (clock),
        .resetb    (resetb),
        .start     (start),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .pattern   (pattern),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [3:0]  pattern;
        logic [37:0] io_out;
        logic [37:0] io_oeb;
        logic        busy;
        logic        done;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: phase -1 idle, 0..3 walking one, 4 all-ones, 5 done
    int   m_phase;
    int   m_elapsed;
    int   m_period;
    bit   m_oe;
    bit   m_loop;

    function automatic void model_reset();
        m_phase   = -1;
        m_elapsed = 0;
        m_period  = 1000;
        m_oe      = 1'b0;
        m_loop    = 1'b0;
    endfunction

    function automatic void model_step(input logic s, input logic we,
                                       input logic [1:0] a, input logic [31:0] wd);
        bit go;
        int len;
        go  = s || (we && a == 2'd0 && wd[1]);
        len = (m_period == 0) ? 1 : m_period;
        if (m_phase == -1 || m_phase == 5) begin
            if (go) begin
                m_phase   = 0;
                m_elapsed = 0;
            end
        end else begin
            m_elapsed++;
            if (m_elapsed >= len) begin
                m_elapsed = 0;
                if (m_phase == 4) m_phase = m_loop ? 0 : 5;
                else              m_phase++;
            end
        end
        if (we && a == 2'd0) begin
            m_oe   = wd[0];
            m_loop = wd[2];
        end
        if (we && a == 2'd1) m_period = int'(wd[15:0]);
    endfunction

    function automatic exp_t model_expect(input logic [1:0] a);
        exp_t e;
        logic [3:0] p;
        logic       b, d;
        if (m_phase < 0)      p = 4'b0000;
        else if (m_phase < 4) p = 4'(1 << m_phase);
        else                  p = 4'b1111;
        b = (m_phase >= 0 && m_phase <= 4);
        d = (m_phase == 5);
        e.pattern = p;
        e.io_out  = 38'(p) << 8;
        e.io_oeb  = ~(38'hF << 8) | (38'({4{~m_oe}}) << 8);
        e.busy    = b;
        e.done    = d;
        case (a)
            2'd0:    e.rdata = {29'd0, m_loop, 1'b0, m_oe};
            2'd1:    e.rdata = 32'(m_period);
            2'd2:    e.rdata = {26'd0, d, b, 1'b0, 3'(m_phase + 1)};
            default: e.rdata = {28'd0, p};
        endcase
        return e;
    endfunction

    // One clock of stimulus: advance the model past the edge, apply new inputs, queue expectation
    task automatic cycle(input logic s, input logic we, input logic [1:0] a,
                         input logic [31:0] wd, input logic rb);
        @(posedge clock);
        #1;
        if (!resetb) model_reset();
        else         model_step(start, reg_we, reg_addr, reg_wdata);
        start     = s;
        reg_we    = we;
        reg_addr  = a;
        reg_wdata = wd;
        resetb    = rb;
        if (!rb) model_reset();
        q.push_back(model_expect(a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'd0, 1'b1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d, 1'b1);
    endtask

    task automatic pulse_start();
        cycle(1'b1, 1'b0, 2'd2, 32'd0, 1'b1);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            bit   bad;
            e   = q.pop_front();
            bad = 1'b0;
            vectors++;
            if (pattern !== e.pattern) begin
                $display("FAIL pattern t=%0t got=%h want=%h", $time, pattern, e.pattern); bad = 1'b1;
            end
            if (io_out !== e.io_out) begin
                $display("FAIL io_out t=%0t got=%h want=%h", $time, io_out, e.io_out); bad = 1'b1;
            end
            if (io_oeb !== e.io_oeb) begin
                $display("FAIL io_oeb t=%0t got=%h want=%h", $time, io_oeb, e.io_oeb); bad = 1'b1;
            end
            if (busy !== e.busy) begin
                $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e.busy); bad = 1'b1;
            end
            if (done !== e.done) begin
                $display("FAIL done t=%0t got=%b want=%b", $time, done, e.done); bad = 1'b1;
            end
            if (reg_rdata !== e.rdata) begin
                $display("FAIL reg_rdata t=%0t addr=%0d got=%h want=%h", $time, reg_addr, reg_rdata, e.rdata);
                bad = 1'b1;
            end
            if (bad) miscompares++;
        end
    end

    initial begin
        resetb    = 1'b0;
        start     = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = 2'd0;
        reg_wdata = 32'd0;
        model_reset();

        // Reset state and reset-value read-back
        cycle(1'b0, 1'b0, 2'd1, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 2'd1, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 2'd2, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);

        // Full sequence with pads enabled, PERIOD=4
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h3);
        idle(26);

        // Pads disabled, hardware start
        wr(2'd0, 32'h0);
        pulse_start();
        idle(24);

        // Looping with PERIOD=2, start ignored mid-sequence
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h5);
        pulse_start();
        idle(7);
        pulse_start();
        idle(20);
        wr(2'd0, 32'h1);
        idle(12);

        // PERIOD=0 behaves as 1
        wr(2'd1, 32'd0);
        pulse_start();
        idle(8);

        // Reset during STEP2, then a clean rerun
        wr(2'd1, 32'd4);
        pulse_start();
        idle(9);
        cycle(1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 2'd1, 32'd0, 1'b0);
        idle(2);
        wr(2'd0, 32'h1);
        pulse_start();
        idle(25);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  a;
            logic [31:0] d;
            logic        we, s, rb;
            a  = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 5) == 0);
            s  = ($urandom_range(0, 19) == 0);
            rb = ($urandom_range(0, 299) != 0);
            d  = (a == 2'd1) ? 32'($urandom_range(0, 5)) : $urandom;
            cycle(s, we, a, d, rb);
        end

        @(negedge clock);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain left=%0d want=0", q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_walk_pattern.md
Name: io_walk_pattern

Overview:
- User-area GPIO pattern generator inside the caravel user project; drives mprj_io[11:8] through a fixed sequence, firmware-controlled via a small register port.
- Sequence: walking one 0001 -> 0010 -> 0100 -> 1000, then all-ones 1111.
- Used as the bring-up check that management-SoC firmware, loaded from SPI flash, can configure the user project and that the user project can drive the pads.

Parameters:
- IO_WIDTH, 38, number of mprj_io pads driven by io_out/io_oeb.
- PAT_LSB, 8, lowest pad index of the 4-bit pattern field (pads PAT_LSB+3..PAT_LSB).
- CNT_W, 16, width of the step-period counter and PERIOD register.
- DEFAULT_PERIOD, 1000, reset value of PERIOD, in clock cycles per step.

Ports:
- clock  in  1  system clock, rising edge.
- resetb  in  1  asynchronous active-low reset.
- start  in  1  hardware start pulse, OR'd with the CTRL.start strobe.
- reg_we  in  1  register write strobe, one cycle.
- reg_addr  in  2  register address.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  combinational read data for reg_addr.
- io_out  out  IO_WIDTH  pad output values.
- io_oeb  out  IO_WIDTH  pad output-enable-bar; 0 = driven.
- pattern  out  4  current pattern, equal to io_out[PAT_LSB+3:PAT_LSB].
- busy  out  1  high while stepping (STEP0..ALL).
- done  out  1  high in DONE.

Behaviour:
- Reset values (async, resetb=0):
  - state=IDLE, pattern=0000, counter=0.
  - CTRL=0, PERIOD=DEFAULT_PERIOD.
  - busy=0, done=0.
  - io_out all 0, io_oeb all 1.
- Registers:
  - addr0 CTRL: bit0 oe_en (R/W); bit1 start (write-1 strobe, self-clearing, reads 0); bit2 loop (R/W).
  - addr1 PERIOD: [CNT_W-1:0] R/W; the value 0 behaves as 1.
  - addr2 STATUS (RO): [2:0] state code, bit4 busy, bit5 done.
  - addr3 PATTERN (RO): [3:0] pattern.
  - Unused bits read 0; writes to RO addresses are ignored.
- States and pattern per state:
  - IDLE = 0, pattern 0000.
  - STEP0 = 1, pattern 0001.
  - STEP1 = 2, pattern 0010.
  - STEP2 = 3, pattern 0100.
  - STEP3 = 4, pattern 1000.
  - ALL = 5, pattern 1111.
  - DONE = 6, pattern 1111 (held).
- Transitions:
  - go = start | (reg_we & reg_addr==0 & reg_wdata[1]).
  - A go in IDLE or DONE moves to STEP0 on the next edge and clears the counter.
  - A go while busy is ignored.
  - Each of STEP0..ALL lasts exactly max(PERIOD,1) cycles, counted from entry.
  - STEPn -> STEPn+1, STEP3 -> ALL.
  - ALL -> DONE, or -> STEP0 if loop=1.
  - DONE holds until go or reset.
- Timing:
  - pattern is registered; it changes on the same edge as the state.
  - STEP0 is visible on the first edge after go.
  - A PERIOD write mid-step applies to the current step's comparison immediately (counter >= PERIOD-1 ends the step).
- Pads:
  - io_out[PAT_LSB+3:PAT_LSB] = pattern; all other io_out bits = 0.
  - io_oeb[PAT_LSB+3:PAT_LSB] = ~oe_en; all other io_oeb bits = 1.
  - Pads 0..7 (including pad 3, the management CSB) are never driven.
- Consistency: the pattern output changes regardless of oe_en; only the pad enable is gated.
- Reset mid-sequence: immediate return to IDLE; outputs tri-stated via io_oeb=1.
- Simultaneous register write and step boundary: the state advances normally; the write takes effect that same edge.

Test Plan:
- Reset asserted then released -> io_oeb all 1, io_out 0, STATUS=0, PERIOD reads 1000.
- Write CTRL=0x3 with PERIOD=4 -> io_out[11:8]: 0001, 0010, 0100, 1000 for 4 cycles each, then 1111 for 4 cycles, then DONE. Afterwards done=1, 1111 held, io_oeb[11:8]=0000.
- oe_en=0, start pulse -> pattern output steps normally, but io_oeb[11:8] stays 1111.
- loop=1, PERIOD=2 -> after ALL, 0001 reappears; done never asserts. A start pulse mid-sequence changes nothing.
- PERIOD=0, start -> each state lasts 1 cycle; DONE is reached 5 cycles after the first pattern.
- resetb low during STEP2 -> immediate pattern 0000 and io_oeb all 1. After release, a new start runs the full sequence from 0001.
